uart_rx: RTL and testbench

//  UART receiver: recovers 8-bit characters from an asynchronous serial line (8 data, 1 parity, 1 stop).

---
 rtl/uart_rx.sv | 210 +++++++++++++++++++++
 tb/tb_uart_rx.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx.sv
// -----------------------------------------------------------------------------
// uart_rx
//   Receives 8-bit characters from an asynchronous serial line. The frame is
//   idle-high, start bit 0, eight data bits LSB first, one parity bit and one
//   stop bit (1). The raw line is brought into the clock domain by a two-flop
//   synchronizer (rx_s) before any use.
//
// Parameters
//   CLK_FREQUENCY  system clock frequency in Hz
//   BAUD_RATE      serial bit rate; BIT_CYCLES = CLK_FREQUENCY / BAUD_RATE
//   PARITY         1 = odd parity, 0 = even parity
//
// Ports
//   clk           in   system clock, all logic on posedge
//   rst_n         in   synchronous active-low reset; aborts any frame
//   rx_in         in   raw asynchronous serial line (idle high)
//   dout          out  last received character, held until the next frame
//   data_strobe   out  one-cycle pulse: dout / parity_error / frame_error
//                      were just updated
//   parity_error  out  1 = parity of the last strobed frame was wrong
//   frame_error   out  1 = stop bit of the last strobed frame sampled low
//   busy          out  high from start-bit detection until the cycle after
//                      the strobe (or until a glitch abort)
//   dbg_state_o   out  current FSM state encoding (debug / checker binding)
//
// Handshake
//   data_strobe is a pure one-cycle valid with no ready. The consumer must
//   capture dout on the strobe cycle; the next frame overwrites it.
// -----------------------------------------------------------------------------
module uart_rx #(
  parameter int CLK_FREQUENCY = 100_000_000,
  parameter int BAUD_RATE     = 19_200,
  parameter bit PARITY        = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx_in,
  output logic [7:0] dout,
  output logic       data_strobe,
  output logic       parity_error,
  output logic       frame_error,
  output logic       busy,
  output logic [2:0] dbg_state_o
);

  localparam int BIT_CYCLES = CLK_FREQUENCY / BAUD_RATE;
  localparam int HALF       = BIT_CYCLES / 2;
  localparam int TW         = $clog2(BIT_CYCLES + 1);

  localparam logic [TW-1:0] BIT_LAST  = TW'(BIT_CYCLES - 1);
  localparam logic [TW-1:0] HALF_LAST = TW'(HALF - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_e;

  // Synchronizer
  logic sync1_q;
  logic rx_s_q;

  // FSM and datapath
  state_e        state_q,  state_d;
  logic [TW-1:0] timer_q,  timer_d;
  logic [2:0]    bitcnt_q, bitcnt_d;
  logic [7:0]    shift_q,  shift_d;
  logic          par_q,    par_d;
  logic [7:0]    dout_q,   dout_d;
  logic          pe_q,     pe_d;
  logic          fe_q,     fe_d;
  logic          strobe_q, strobe_d;

  logic bit_done;
  logic half_done;

  assign bit_done  = (timer_q == BIT_LAST);
  assign half_done = (timer_q == HALF_LAST);

  // ---------------------------------------------------------------------------
  // State register (also holds synchronizer and datapath registers).
  // Synchronizer flops reset to 1 so a reset never looks like a start bit.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1_q  <= 1'b1;
      rx_s_q   <= 1'b1;
      state_q  <= S_IDLE;
      timer_q  <= '0;
      bitcnt_q <= '0;
      shift_q  <= '0;
      par_q    <= 1'b0;
      dout_q   <= '0;
      pe_q     <= 1'b0;
      fe_q     <= 1'b0;
      strobe_q <= 1'b0;
    end else begin
      sync1_q  <= rx_in;
      rx_s_q   <= sync1_q;
      state_q  <= state_d;
      timer_q  <= timer_d;
      bitcnt_q <= bitcnt_d;
      shift_q  <= shift_d;
      par_q    <= par_d;
      dout_q   <= dout_d;
      pe_q     <= pe_d;
      fe_q     <= fe_d;
      strobe_q <= strobe_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic.
  // The START state waits half a bit so every later sample, taken one full
  // bit period apart, lands at the centre of its bit.
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d  = state_q;
    timer_d  = timer_q;
    bitcnt_d = bitcnt_q;
    shift_d  = shift_q;
    par_d    = par_q;
    dout_d   = dout_q;
    pe_d     = pe_q;
    fe_d     = fe_q;
    strobe_d = 1'b0;

    case (state_q)
      S_IDLE: begin
        timer_d = '0;
        if (!rx_s_q) begin
          state_d = S_START;
        end
      end

      S_START: begin
        if (half_done) begin
          timer_d  = '0;
          bitcnt_d = '0;
          // Line back high at mid start bit: treat as a glitch and re-arm.
          state_d  = rx_s_q ? S_IDLE : S_DATA;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end

      S_DATA: begin
        if (bit_done) begin
          timer_d = '0;
          // LSB arrives first, so shift in at the MSB and move right.
          shift_d = {rx_s_q, shift_q[7:1]};
          if (bitcnt_q == 3'd7) begin
            state_d = S_PARITY;
          end else begin
            bitcnt_d = bitcnt_q + 3'd1;
          end
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end

      S_PARITY: begin
        if (bit_done) begin
          timer_d = '0;
          par_d   = rx_s_q;
          state_d = S_STOP;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end

      S_STOP: begin
        if (bit_done) begin
          // Sampled mid stop bit: publish the frame and re-arm immediately so
          // a following start edge half a bit later is not missed.
          timer_d  = '0;
          dout_d   = shift_q;
          pe_d     = ((^{shift_q, par_q}) != PARITY);
          fe_d     = ~rx_s_q;
          strobe_d = 1'b1;
          state_d  = S_IDLE;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end

      default: begin
        state_d = S_IDLE;
        timer_d = '0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Outputs.
  // The strobe is registered, so it is high in the first IDLE cycle; busy is
  // stretched over that cycle so it drops the cycle after the strobe.
  // ---------------------------------------------------------------------------
  always_comb begin
    dout         = dout_q;
    data_strobe  = strobe_q;
    parity_error = pe_q;
    frame_error  = fe_q;
    busy         = (state_q != S_IDLE) || strobe_q;
    dbg_state_o  = state_q;
  end

endmodule

// File: tb/tb_uart_rx.sv
// -----------------------------------------------------------------------------
// tb_uart_rx
//   Directed bench for uart_rx with a 32-cycle bit period. One time unit is
//   treated as 1 ps-scale tick; the clock period is 1000 units so baud skew
//   of +/-2 % can be expressed as integer bit times (31360 / 32640).
// -----------------------------------------------------------------------------
module tb_uart_rx;

  localparam int CLK_FREQ = 3_200_000;
  localparam int BAUD     = 100_000;
  localparam int BC       = CLK_FREQ / BAUD;   // 32 cycles per bit
  localparam int CLK_T    = 1000;
  localparam int BIT_T    = BC * CLK_T;        // 32000
  localparam int BIT_FAST = 31360;             // +2 % baud
  localparam int BIT_SLOW = 32640;             // -2 % baud

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  logic       clk = 1'b0;
  logic       rst_n;
  logic       rx_in;
  logic [7:0] dout;
  logic       data_strobe;
  logic       parity_error;
  logic       frame_error;
  logic       busy;
  logic [2:0] dbg_state;

  always #(CLK_T / 2) clk = ~clk;

  uart_rx #(
    .CLK_FREQUENCY (CLK_FREQ),
    .BAUD_RATE     (BAUD),
    .PARITY        (1'b1)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .rx_in        (rx_in),
    .dout         (dout),
    .data_strobe  (data_strobe),
    .parity_error (parity_error),
    .frame_error  (frame_error),
    .busy         (busy),
    .dbg_state_o  (dbg_state)
  );

  // ---------------------------------------------------------------------------
  // Bookkeeping
  // ---------------------------------------------------------------------------
  int         n_checks   = 0;
  int         n_fail     = 0;
  int         strobe_cnt = 0;
  logic       busy_seen  = 1'b0;
  logic       prev_strobe = 1'b0;
  logic [9:0] exp_q[$];          // {frame_error, parity_error, dout}
  logic [9:0] mon_e;

  task automatic check_eq(input string tag, input logic [31:0] act,
                          input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  function automatic logic odd_par(input logic [7:0] d);
    return ~(^d);
  endfunction

  // Expected result of a frame, derived from the line contents only.
  function automatic logic [9:0] frame_result(input logic [7:0] d,
                                              input logic par,
                                              input logic stop);
    logic pe;
    pe = (((^d) ^ par) != 1'b1);
    return {~stop, pe, d};
  endfunction

  // ---------------------------------------------------------------------------
  // Driver tasks
  // ---------------------------------------------------------------------------
  task automatic send_frame(input logic [7:0] d, input logic par,
                            input logic stop, input int bit_t);
    exp_q.push_back(frame_result(d, par, stop));
    rx_in = 1'b0;
    #(bit_t);
    for (int i = 0; i < 8; i++) begin
      rx_in = d[i];
      #(bit_t);
    end
    rx_in = par;
    #(bit_t);
    rx_in = stop;
    #(bit_t);
    rx_in = 1'b1;
  endtask

  task automatic idle_bits(input int n);
    rx_in = 1'b1;
    repeat (n * BC) @(negedge clk);
  endtask

  task automatic wait_drain(input string tag);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || busy) && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check_eq(tag, exp_q.size(), 0);
  endtask

  // ---------------------------------------------------------------------------
  // Scoreboard: every strobe pops one expected frame result.
  // ---------------------------------------------------------------------------
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (busy) busy_seen = 1'b1;
      if (data_strobe) begin
        strobe_cnt++;
        check_eq("strobe_width", prev_strobe, 0);
        if (exp_q.size() == 0) begin
          check_eq("unexpected_strobe", 1, 0);
        end else begin
          mon_e = exp_q.pop_front();
          check_eq("dout",         dout,         mon_e[7:0]);
          check_eq("parity_error", parity_error, mon_e[8]);
          check_eq("frame_error",  frame_error,  mon_e[9]);
        end
      end
      prev_strobe = data_strobe;
    end else begin
      prev_strobe = 1'b0;
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  int lat;
  int cnt_before;

  initial begin
    rst_n = 1'b0;
    rx_in = 1'b1;
    repeat (3) @(negedge clk);
    check_eq("rst_busy",   busy,         0);
    check_eq("rst_dout",   dout,         8'h00);
    check_eq("rst_strobe", data_strobe,  0);
    check_eq("rst_pe",     parity_error, 0);
    check_eq("rst_fe",     frame_error,  0);
    check_eq("rst_state",  dbg_state,    0);
    rst_n = 1'b1;

    // 1. Idle line for 20 bit times.
    busy_seen = 1'b0;
    idle_bits(20);
    check_eq("idle_busy_seen", busy_seen,  0);
    check_eq("idle_strobes",   strobe_cnt, 0);
    check_eq("idle_dout",      dout,       8'h00);

    // 2. 0xA5 with correct odd parity; also measure start-edge-to-strobe
    //    latency: 10.5 bit times plus 3 cycles of synchronizer / IDLE detect.
    lat = 0;
    fork
      send_frame(8'hA5, odd_par(8'hA5), 1'b1, BIT_T);
      begin
        while (!data_strobe && lat < 1000) begin
          @(negedge clk);
          lat++;
        end
      end
    join
    check_eq("latency", lat, 10 * BC + BC / 2 + 3);
    wait_drain("drain_a5");
    check_eq("strobes_a5", strobe_cnt, 1);

    // 3. 0x3C with the wrong parity bit.
    idle_bits(2);
    send_frame(8'h3C, ~odd_par(8'h3C), 1'b1, BIT_T);
    wait_drain("drain_3c");
    check_eq("strobes_3c", strobe_cnt, 2);

    // 4. Quarter-bit glitch on the idle line.
    idle_bits(2);
    busy_seen = 1'b0;
    rx_in = 1'b0;
    repeat (BC / 4) @(negedge clk);
    rx_in = 1'b1;
    idle_bits(2);
    check_eq("glitch_busy_seen", busy_seen,  1);
    check_eq("glitch_strobes",   strobe_cnt, 2);
    check_eq("glitch_dout",      dout,       8'h3C);
    check_eq("glitch_pe_held",   parity_error, 1);
    check_eq("glitch_busy_end",  busy,       0);

    // 5. Framing error, then a clean frame.
    send_frame(8'h00, odd_par(8'h00), 1'b0, BIT_T);
    idle_bits(2);
    check_eq("fe_sticky",   frame_error, 1);
    check_eq("fe_dout",     dout,        8'h00);
    check_eq("strobes_fe",  strobe_cnt,  3);
    send_frame(8'hFF, odd_par(8'hFF), 1'b1, BIT_T);
    wait_drain("drain_ff");
    check_eq("fe_cleared",  frame_error, 0);

    // 6a. Back-to-back frames with no idle gap, transmitter 2 % fast.
    idle_bits(2);
    send_frame(8'h01, odd_par(8'h01), 1'b1, BIT_FAST);
    send_frame(8'h80, odd_par(8'h80), 1'b1, BIT_FAST);
    send_frame(8'h55, odd_par(8'h55), 1'b1, BIT_FAST);
    wait_drain("drain_fast");
    check_eq("strobes_fast", strobe_cnt, 7);

    // 6b. Same, transmitter 2 % slow.
    idle_bits(2);
    send_frame(8'h01, odd_par(8'h01), 1'b1, BIT_SLOW);
    send_frame(8'h80, odd_par(8'h80), 1'b1, BIT_SLOW);
    send_frame(8'h55, odd_par(8'h55), 1'b1, BIT_SLOW);
    wait_drain("drain_slow");
    check_eq("strobes_slow", strobe_cnt, 10);

    // 6c. Reset in the middle of data bit 4 aborts the frame.
    idle_bits(2);
    rx_in = 1'b0;
    #(BIT_T);
    for (int i = 0; i < 4; i++) begin
      rx_in = 1'b1 ^ i[0];
      #(BIT_T);
    end
    rx_in = 1'b0;
    #(BIT_T / 2);
    @(negedge clk);
    check_eq("pre_rst_busy", busy, 1);
    rst_n = 1'b0;
    rx_in = 1'b1;
    @(negedge clk);
    check_eq("midrst_busy",   busy,        0);
    check_eq("midrst_strobe", data_strobe, 0);
    check_eq("midrst_dout",   dout,        8'h00);
    @(negedge clk);
    rst_n = 1'b1;
    cnt_before = strobe_cnt;
    idle_bits(4);
    check_eq("midrst_no_strobe", strobe_cnt, cnt_before);
    send_frame(8'h5A, odd_par(8'h5A), 1'b1, BIT_T);
    wait_drain("drain_after_rst");
    check_eq("strobes_total", strobe_cnt, 11);
    check_eq("final_dout",    dout,       8'h5A);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
